// File: rtl/flit_sink_if.sv
// Flit input bundle from the mux output into the sink.
interface flit_sink_if #(
  parameter int DATAW = 66,
  parameter int VCHW  = 2
);
  logic [DATAW-1:0] idata;
  logic             ivalid;
  logic [VCHW-1:0]  ivch;

  modport master (output idata, ivalid, ivch);
  modport slave  (input  idata, ivalid, ivch);
endinterface

// File: rtl/flit_sink.sv
// Flit sink: tracks packet framing per HEAD/DATA/TAIL, collects packet, flit
// and bit-toggle statistics, and latches the first protocol error.

module flit_sink_popcnt #(
  parameter int VEC_W = 8,
  parameter int CNTW  = 4
) (
  input  logic [VEC_W-1:0] vec,
  output logic [CNTW-1:0]  cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < VEC_W; i++) cnt = cnt + CNTW'(vec[i]);
  end
endmodule

module flit_sink #(
  parameter int DATAW = 66,
  parameter int VCHW  = 2,
  parameter int LENW  = 8,
  parameter int ACCW  = 32
) (
  input  logic              clk,
  input  logic              rst,
  flit_sink_if.slave        flit,
  input  logic              clr,
  output logic              pkt_done,
  output logic [15:0]       pkt_cnt,
  output logic [LENW-1:0]   last_len,
  output logic [31:0]       flit_cnt,
  output logic [ACCW-1:0]   toggle_acc,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam int VEC_W     = 8;
  localparam int NUM_LANES = (DATAW + VEC_W - 1) / VEC_W;
  localparam int PADW      = NUM_LANES * VEC_W;
  localparam int LCW       = $clog2(VEC_W + 1);
  localparam int CNTW      = $clog2(DATAW + 1);

  typedef enum logic [1:0] {
    T_NONE = 2'b00,
    T_HEAD = 2'b01,
    T_TAIL = 2'b10,
    T_DATA = 2'b11
  } ftype_t;

  typedef enum logic {IDLE, BODY} state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] code;
  } err_ev_t;

  state_t           state, state_nx;
  ftype_t           ftype;
  logic [VCHW-1:0]  vc_q;
  logic [LENW-1:0]  len_q;
  logic [DATAW-1:0] prev_q;
  logic             vc_load, len_clr, len_inc, tail_hit;
  err_ev_t          ev;

  assign ftype = ftype_t'(flit.idata[DATAW-1 -: 2]);

  // Framing decisions. The VC check is evaluated before the flit type so a
  // mid-packet HEAD reports 01 rather than the VC mismatch.
  always_comb begin
    state_nx = state;
    vc_load  = 1'b0;
    len_clr  = 1'b0;
    len_inc  = 1'b0;
    tail_hit = 1'b0;
    ev       = '0;
    if (flit.ivalid) begin
      if (state == BODY && flit.ivch != vc_q) ev = '{hit: 1'b1, code: 2'b11};
      case (ftype)
        T_HEAD: begin
          if (state == BODY) ev = '{hit: 1'b1, code: 2'b01};
          state_nx = BODY;
          vc_load  = 1'b1;
          len_clr  = 1'b1;
        end
        T_DATA: begin
          if (state == BODY) len_inc = 1'b1;
          else               ev = '{hit: 1'b1, code: 2'b10};
        end
        T_TAIL: begin
          if (state == BODY) begin
            state_nx = IDLE;
            tail_hit = 1'b1;
          end else begin
            ev = '{hit: 1'b1, code: 2'b10};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vc_q  <= '0;
      len_q <= '0;
    end else begin
      state <= state_nx;
      if (vc_load) vc_q <= flit.ivch;
      if (len_clr)                       len_q <= '0;
      else if (len_inc && len_q != '1)   len_q <= len_q + LENW'(1);
    end
  end

  // Hamming distance to the previous flit, split into byte lanes.
  logic [NUM_LANES-1:0][VEC_W-1:0] diff_lanes;
  logic [NUM_LANES-1:0][LCW-1:0]   lane_cnt;
  logic [CNTW-1:0]                 pop_sum;

  assign diff_lanes = PADW'(flit.idata ^ prev_q);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    flit_sink_popcnt #(.VEC_W(VEC_W), .CNTW(LCW)) u_pc (
      .vec (diff_lanes[g]),
      .cnt (lane_cnt[g])
    );
  end

  always_comb begin
    pop_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) pop_sum = pop_sum + CNTW'(lane_cnt[i]);
  end

  // pkt_done follows the FSM even under clr; only the counters drop the flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_done   <= 1'b0;
      pkt_cnt    <= '0;
      last_len   <= '0;
      flit_cnt   <= '0;
      toggle_acc <= '0;
      err        <= 1'b0;
      err_code   <= '0;
      prev_q     <= '0;
    end else begin
      pkt_done <= tail_hit;
      if (clr) begin
        pkt_cnt    <= '0;
        last_len   <= '0;
        flit_cnt   <= '0;
        toggle_acc <= '0;
        err        <= 1'b0;
        err_code   <= '0;
        prev_q     <= '0;
      end else if (flit.ivalid) begin
        flit_cnt   <= flit_cnt + 32'd1;
        toggle_acc <= toggle_acc + ACCW'(pop_sum);
        prev_q     <= flit.idata;
        if (tail_hit) begin
          pkt_cnt  <= pkt_cnt + 16'd1;
          last_len <= len_q;
        end
        if (ev.hit && !err) begin
          err      <= 1'b1;
          err_code <= ev.code;
        end
      end
    end
  end
endmodule

// File: tb/tb_flit_sink.sv
// Directed + randomized bench for flit_sink against a behavioural packet model.
module tb_flit_sink;
  localparam int DATAW = 66;
  localparam int VCHW  = 2;
  localparam int LENW  = 8;
  localparam int ACCW  = 32;

  localparam logic [1:0] NONE = 2'b00, HEAD = 2'b01, TAIL = 2'b10, DATA = 2'b11;

  logic clk = 1'b0;
  logic rst, clr;
  logic             pkt_done, err;
  logic [15:0]      pkt_cnt;
  logic [LENW-1:0]  last_len;
  logic [31:0]      flit_cnt;
  logic [ACCW-1:0]  toggle_acc;
  logic [1:0]       err_code;

  flit_sink_if #(.DATAW(DATAW), .VCHW(VCHW)) flit ();

  flit_sink #(.DATAW(DATAW), .VCHW(VCHW), .LENW(LENW), .ACCW(ACCW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flit       (flit),
    .clr        (clr),
    .pkt_done   (pkt_done),
    .pkt_cnt    (pkt_cnt),
    .last_len   (last_len),
    .flit_cnt   (flit_cnt),
    .toggle_acc (toggle_acc),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;

  // Reference model: packet framing by rule, stats by plain arithmetic.
  bit               m_in_pkt;
  logic [VCHW-1:0]  m_vc;
  int               m_len;
  logic [15:0]      m_pkt;
  logic [7:0]       m_last;
  logic [31:0]      m_flits;
  logic [31:0]      m_tog;
  logic [DATAW-1:0] m_prev;
  logic             m_err;
  logic [1:0]       m_code;
  logic             m_done;

  task automatic model(input logic [DATAW-1:0] d, input logic [VCHW-1:0] vc,
                       input logic v, input logic c, input logic r);
    logic [1:0] t;
    bit         e, tail;
    logic [1:0] code;
    int         tl;
    t = d[DATAW-1 -: 2];
    e = 0; tail = 0; code = 2'b00; tl = 0;
    if (r) begin
      m_in_pkt = 0; m_vc = '0; m_len = 0; m_pkt = '0; m_last = '0; m_flits = '0;
      m_tog = '0; m_prev = '0; m_err = 0; m_code = '0; m_done = 0;
      return;
    end
    if (v) begin
      if (m_in_pkt && vc != m_vc) begin e = 1; code = 2'b11; end
      case (t)
        HEAD: begin
          if (m_in_pkt) begin e = 1; code = 2'b01; end
          m_in_pkt = 1; m_vc = vc; m_len = 0;
        end
        DATA: begin
          if (!m_in_pkt) begin e = 1; code = 2'b10; end
          else if (m_len < 255) m_len++;
        end
        TAIL: begin
          if (!m_in_pkt) begin e = 1; code = 2'b10; end
          else begin m_in_pkt = 0; tail = 1; tl = m_len; end
        end
        default: ;
      endcase
    end
    m_done = tail;
    if (c) begin
      m_pkt = '0; m_last = '0; m_flits = '0; m_tog = '0; m_prev = '0; m_err = 0; m_code = '0;
    end else if (v) begin
      m_flits = m_flits + 1;
      m_tog   = m_tog + 32'($countones(d ^ m_prev));
      m_prev  = d;
      if (tail) begin m_pkt = m_pkt + 1; m_last = 8'(tl); end
      if (e && !m_err) begin m_err = 1; m_code = code; end
    end
  endtask

  task automatic step(input logic [DATAW-1:0] d, input logic [VCHW-1:0] vc,
                      input logic v, input logic c, input logic r);
    @(negedge clk);
    flit.idata = d; flit.ivch = vc; flit.ivalid = v; clr = c; rst = r;
    @(posedge clk);
    model(d, vc, v, c, r);
    #1;
    if (pkt_done === 1'b1) done_seen++;
  endtask

  function automatic logic [DATAW-1:0] mk(input logic [1:0] t);
    logic [63:0] pl;
    pl = {$urandom(), $urandom()};
    return {t, pl};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(NONE), '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(mk(DATA), 2'd3, 1'b1, 1'b1, 1'b1);
    step(mk(HEAD), 2'd1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pkt_done !== 1'b0) begin n_bad++; $display("FAIL reset_pkt_done: got %0d want 0", pkt_done); end
    n_cmp++; if (pkt_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
    n_cmp++; if (last_len !== 8'd0) begin n_bad++; $display("FAIL reset_last_len: got %0d want 0", last_len); end
    n_cmp++; if (flit_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_flit_cnt: got %0d want 0", flit_cnt); end
    n_cmp++; if (toggle_acc !== 32'd0) begin n_bad++; $display("FAIL reset_toggle_acc: got %0d want 0", toggle_acc); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", err); end
    n_cmp++; if (err_code !== 2'd0) begin n_bad++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
  endtask

  task automatic test_single_pkt();
    do_reset();
    done_seen = 0;
    step(mk(HEAD), 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(mk(DATA), 2'd0, 1'b1, 1'b0, 1'b0);
    step(mk(TAIL), 2'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (pkt_done !== 1'b1) begin n_bad++; $display("FAIL single_done_edge: got %0d want 1", pkt_done); end
    n_cmp++; if (pkt_cnt !== 16'd1) begin n_bad++; $display("FAIL single_pkt_cnt: got %0d want 1", pkt_cnt); end
    idle(1);
    n_cmp++; if (pkt_done !== 1'b0) begin n_bad++; $display("FAIL single_done_drop: got %0d want 0", pkt_done); end
    n_cmp++; if (done_seen != 1) begin n_bad++; $display("FAIL single_pulses: got %0d want 1", done_seen); end
    n_cmp++; if (last_len !== 8'd20) begin n_bad++; $display("FAIL single_last_len: got %0d want 20", last_len); end
    n_cmp++; if (flit_cnt !== 32'd22) begin n_bad++; $display("FAIL single_flit_cnt: got %0d want 22", flit_cnt); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %0d want 0", err); end
    n_cmp++; if (toggle_acc !== m_tog) begin n_bad++; $display("FAIL single_toggle: got %0d want %0d", toggle_acc, m_tog); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    done_seen = 0;
    for (int p = 0; p < 10; p++) begin
      step(mk(HEAD), 2'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(mk(DATA), 2'd0, 1'b1, 1'b0, 1'b0);
      step(mk(TAIL), 2'd0, 1'b1, 1'b0, 1'b0);
      idle(7);
    end
    n_cmp++; if (pkt_cnt !== 16'd10) begin n_bad++; $display("FAIL b2b_pkt_cnt: got %0d want 10", pkt_cnt); end
    n_cmp++; if (flit_cnt !== 32'd220) begin n_bad++; $display("FAIL b2b_flit_cnt: got %0d want 220", flit_cnt); end
    n_cmp++; if (done_seen != 10) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 10", done_seen); end
    n_cmp++; if (toggle_acc !== m_tog) begin n_bad++; $display("FAIL b2b_toggle: got %0d want %0d", toggle_acc, m_tog); end
  endtask

  task automatic test_toggle();
    logic [DATAW-1:0] zero, ones;
    zero = '0; ones = '1;
    do_reset();
    step(zero, 2'd0, 1'b1, 1'b0, 1'b0);
    step(ones, 2'd0, 1'b1, 1'b0, 1'b0);
    step(zero, 2'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (toggle_acc !== 32'd132) begin n_bad++; $display("FAIL toggle_direct: got %0d want 132", toggle_acc); end
    step(mk(NONE), 2'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (toggle_acc !== 32'd0) begin n_bad++; $display("FAIL toggle_clr: got %0d want 0", toggle_acc); end
    step(zero, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(ones, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(zero, 2'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (toggle_acc !== 32'd132) begin n_bad++; $display("FAIL toggle_idle_gap: got %0d want 132", toggle_acc); end
    n_cmp++; if (toggle_acc !== m_tog) begin n_bad++; $display("FAIL toggle_model: got %0d want %0d", toggle_acc, m_tog); end
  endtask

  task automatic test_errors();
    do_reset();
    step(mk(DATA), 2'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_idle_data: got %0d want 1", err); end
    n_cmp++; if (err_code !== 2'b10) begin n_bad++; $display("FAIL err_idle_code: got %0d want 2", err_code); end
    step(mk(HEAD), 2'd0, 1'b1, 1'b0, 1'b0);
    step(mk(HEAD), 2'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (err_code !== 2'b10) begin n_bad++; $display("FAIL err_first_kept: got %0d want 2", err_code); end
    step(mk(NONE), 2'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clr: got %0d want 0", err); end
    n_cmp++; if (err_code !== 2'b00) begin n_bad++; $display("FAIL err_clr_code: got %0d want 0", err_code); end
    // FSM stayed in BODY across clr: a second HEAD is now the first error
    step(mk(HEAD), 2'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (err_code !== 2'b01) begin n_bad++; $display("FAIL err_head_body: got %0d want 1", err_code); end
  endtask

  task automatic test_vc_change();
    do_reset();
    step(mk(HEAD), 2'd1, 1'b1, 1'b0, 1'b0);
    step(mk(DATA), 2'd2, 1'b1, 1'b0, 1'b0);
    step(mk(TAIL), 2'd1, 1'b1, 1'b0, 1'b0);
    idle(1);
    n_cmp++; if (err_code !== 2'b11) begin n_bad++; $display("FAIL vc_code: got %0d want 3", err_code); end
    n_cmp++; if (pkt_cnt !== 16'd1) begin n_bad++; $display("FAIL vc_pkt_cnt: got %0d want 1", pkt_cnt); end
    n_cmp++; if (last_len !== 8'd1) begin n_bad++; $display("FAIL vc_last_len: got %0d want 1", last_len); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(mk(HEAD), 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(mk(DATA), 2'd0, 1'b1, 1'b0, 1'b0);
    step(mk(NONE), 2'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if ({pkt_done, pkt_cnt, last_len, flit_cnt, toggle_acc, err, err_code} !== '0) begin
      n_bad++; $display("FAIL rstmid_zero: got cnt=%0d flits=%0d tog=%0d err=%0d want all 0", pkt_cnt, flit_cnt, toggle_acc, err);
    end
    for (int i = 0; i < 15; i++) step(mk(DATA), 2'd0, 1'b1, 1'b0, 1'b0);
    step(mk(TAIL), 2'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (err_code !== 2'b10) begin n_bad++; $display("FAIL rstmid_code: got %0d want 2", err_code); end
    n_cmp++; if (pkt_cnt !== 16'd0) begin n_bad++; $display("FAIL rstmid_pkt_cnt: got %0d want 0", pkt_cnt); end
    n_cmp++; if (flit_cnt !== 32'd16) begin n_bad++; $display("FAIL rstmid_flit_cnt: got %0d want 16", flit_cnt); end
  endtask

  task automatic test_clr_same_cycle();
    do_reset();
    step(mk(HEAD), 2'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(mk(DATA), 2'd2, 1'b1, 1'b0, 1'b0);
    step(mk(TAIL), 2'd2, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (pkt_cnt !== 16'd1) begin n_bad++; $display("FAIL clrsame_pkt_cnt: got %0d want 1", pkt_cnt); end
    n_cmp++; if (last_len !== 8'd3) begin n_bad++; $display("FAIL clrsame_last_len: got %0d want 3", last_len); end
    n_cmp++; if (flit_cnt !== 32'd4) begin n_bad++; $display("FAIL clrsame_flit_cnt: got %0d want 4", flit_cnt); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clrsame_err: got %0d want 0", err); end
  endtask

  task automatic test_len_saturate();
    do_reset();
    step(mk(HEAD), 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(mk(DATA), 2'd0, 1'b1, 1'b0, 1'b0);
    step(mk(TAIL), 2'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (last_len !== 8'd255) begin n_bad++; $display("FAIL len_saturate: got %0d want 255", last_len); end
  endtask

  task automatic test_random();
    logic [VCHW-1:0] cur_vc;
    logic [1:0]      t;
    int              r;
    do_reset();
    cur_vc = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      r = $urandom_range(0, 9);
      t = (r == 0) ? NONE : (r < 3) ? HEAD : (r < 8) ? DATA : TAIL;
      if ($urandom_range(0, 99) < 15) cur_vc = VCHW'($urandom());
      step(mk(t), cur_vc, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) == 0);
      n_cmp++; if (pkt_done !== m_done) begin n_bad++; $display("FAIL rnd_pkt_done @%0d: got %0d want %0d", cyc, pkt_done, m_done); end
      n_cmp++; if (pkt_cnt !== m_pkt) begin n_bad++; $display("FAIL rnd_pkt_cnt @%0d: got %0d want %0d", cyc, pkt_cnt, m_pkt); end
      n_cmp++; if (last_len !== m_last) begin n_bad++; $display("FAIL rnd_last_len @%0d: got %0d want %0d", cyc, last_len, m_last); end
      n_cmp++; if (flit_cnt !== m_flits) begin n_bad++; $display("FAIL rnd_flit_cnt @%0d: got %0d want %0d", cyc, flit_cnt, m_flits); end
      n_cmp++; if (toggle_acc !== m_tog) begin n_bad++; $display("FAIL rnd_toggle @%0d: got %0d want %0d", cyc, toggle_acc, m_tog); end
      n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL rnd_err @%0d: got %0d want %0d", cyc, err, m_err); end
      n_cmp++; if (err_code !== m_code) begin n_bad++; $display("FAIL rnd_err_code @%0d: got %0d want %0d", cyc, err_code, m_code); end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    flit.idata = '0; flit.ivalid = 1'b0; flit.ivch = '0;
    test_reset();
    test_single_pkt();
    test_back_to_back();
    test_toggle();
    test_errors();
    test_vc_change();
    test_reset_mid();
    test_clr_same_cycle();
    test_len_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/flit_sink.md
FLIT_SINK -- requirements
Module: flit_sink

Interface
REQ-001 Parameter DATAW, default 66; flit width in bits.
REQ-002 Parameter VCHW, default 2; virtual-channel field width in bits.
REQ-003 Parameter LENW, default 8; payload-length counter width in bits.
REQ-004 Parameter ACCW, default 32; toggle accumulator width in bits.
REQ-005 Reset is synchronous and active-high; one clock (clk), rising edge.
REQ-006 Port clk, input, 1; clock.
REQ-007 Port rst, input, 1; synchronous active-high reset.
REQ-008 Port idata, input, DATAW; flit from the mux output. Type field is idata[DATAW-1:DATAW-2]: NONE=2'b00, HEAD=2'b01, TAIL=2'b10, DATA=2'b11.
REQ-009 Port ivalid, input, 1; flit valid.
REQ-010 Port ivch, input, VCHW; virtual channel of the flit.
REQ-011 Port clr, input, 1; synchronous clear of the statistics outputs.
REQ-012 Port pkt_done, output, 1; one-cycle pulse when a tail flit is accepted.
REQ-013 Port pkt_cnt, output, 16; count of completed packets.
REQ-014 Port last_len, output, LENW; number of DATA flits in the last completed packet.
REQ-015 Port flit_cnt, output, 32; count of accepted valid flits.
REQ-016 Port toggle_acc, output, ACCW; sum of Hamming distances between consecutive accepted flits.
REQ-017 Port err, output, 1; sticky protocol-error flag.
REQ-018 Port err_code, output, 2; first error cause: 01 = unexpected HEAD, 10 = DATA/TAIL outside a packet, 11 = VC change mid-packet.

Function
REQ-019 A flit is accepted on each rising edge of clk where ivalid=1; the block is always ready and has no backpressure.
REQ-020 The FSM has the states IDLE and BODY.
- IDLE + HEAD: go to BODY, latch ivch, clear the length counter.
- BODY + DATA: increment the length counter; it saturates at all-ones.
- BODY + TAIL: go to IDLE, pulse pkt_done, increment pkt_cnt, load last_len.
REQ-021 pkt_done asserts in the cycle after the tail flit is sampled (registered output) and stays high for exactly one cycle.
REQ-022 A type-NONE flit with ivalid=1 is counted in flit_cnt and toggle_acc and does not change the FSM state.
REQ-023 Error cases:
- BODY + HEAD: set err with code 01, then restart the packet (stay in BODY, latch the new VC, clear the length).
- IDLE + DATA or IDLE + TAIL: set err with code 10 and stay in IDLE.
- BODY + valid flit whose ivch differs from the latched VC: set err with code 11 and process the flit type normally.
REQ-024 err_code captures only the first error after reset or clr; later errors leave it unchanged.
REQ-025 On each accepted flit, toggle_acc increases by popcount(idata XOR prev), where prev is the last accepted flit.
- prev is 0 after reset or clr.
- prev is updated only on accepted flits; idle cycles do not update it.
REQ-026 toggle_acc, flit_cnt and pkt_cnt wrap modulo 2^width with no saturation flag.
REQ-027 clr=1 zeroes the statistics (pkt_cnt, last_len, flit_cnt, toggle_acc, err, err_code, prev) and leaves the FSM state unchanged.
- A flit accepted in the same cycle as clr is discarded from the statistics.
- That flit still advances the FSM.
REQ-028 Outputs are registered.
- Statistics become visible one cycle after the accepting edge.
- pkt_cnt and last_len update in the same cycle that pkt_done is high.

Reset
REQ-029 With rst=1, on the next rising edge every register is cleared and the FSM enters IDLE. All outputs read 0: pkt_done, pkt_cnt, last_len, flit_cnt, toggle_acc, err, err_code.
REQ-030 rst has priority over clr and ivalid.
REQ-031 A reset in the middle of a packet drops that packet.
- The following DATA/TAIL flits of the dropped packet raise err with code 10.

Verification
REQ-032 HEAD, 20 DATA, TAIL, all with ivalid=1 on VC 0 -> one pkt_done pulse, pkt_cnt=1, last_len=20, flit_cnt=22, err=0.
REQ-033 10 packets of 20 DATA flits, separated by 7 idle cycles -> pkt_cnt=10, flit_cnt=220, exactly 10 pkt_done pulses.
REQ-034 Flits 0, all-ones (66 bits), 0 -> toggle_acc=132; an idle cycle between the flits does not change this result.
REQ-035 Error cases:
- DATA while IDLE -> err=1, err_code=10.
- A later HEAD, HEAD sequence -> err_code stays 10.
- After clr -> err=0.
REQ-036 HEAD on VC 1 then DATA on VC 2 -> err_code=11; the following TAIL still completes the packet (pkt_cnt=1).
REQ-037 rst asserted after HEAD and 5 DATA flits -> all outputs 0 next cycle; the remaining DATA flits give err_code=10 and pkt_cnt stays 0.
